ext_int_controller: RTL and testbench
=====================================

// Module: ext_int_controller
// PURPOSE
//  Multi-channel external interrupt controller: NUM_CHANNELS pins, each with its own enable,
//  sense mode and optional debounce. Latches events into pending flags and arbitrates them
//  (fixed priority, channel 0 highest) onto one valid/ack request toward the interrupt unit.
//  Successor of the single-pin edge handler; adds low-level sense, W1C pending and arbitration.
// PARAMETERS
//  NUM_CHANNELS     4                        number of external interrupt pins (>=1)
//  PIN_IDLE_STATE   1                        reset value of each pin-history register
//  DEBOUNCE_TIMEOUT 20                       blanking cycles after an accepted edge (>=1)
//  DEBOUNCE_CNT_W   $clog2(DEBOUNCE_TIMEOUT+1) debounce counter width
//  ID_W             (NUM_CHANNELS>1)?$clog2(NUM_CHANNELS):1  irq_id width
// PORTS
//  clk           in   1                clock, all logic on posedge
//  rst           in   1                synchronous reset, active-high
//  int_pin       in   NUM_CHANNELS     external pins (async unless EXT_INT_SYNC_EN)
//  int_enable    in   NUM_CHANNELS     per-channel detection enable
//  sense_control in   2*NUM_CHANNELS   ch i at [2i+1:2i]: 00 rise, 01 fall, 10 change, 11 low-level
//  debounce_en   in   NUM_CHANNELS     per-channel debounce enable (edge modes only)
//  pending_clr   in   NUM_CHANNELS     write-1-to-clear pending flags, 1-cycle pulses
//  pending       out  NUM_CHANNELS     latched pending flags
//  irq_valid     out  1                request to interrupt unit
//  irq_id        out  ID_W             index of requested channel
//  irq_ack       in   1                acceptance of current request
// BEHAVIOUR
//  Reset: pending=0, irq_valid=0, irq_id=0, pin history=PIN_IDLE_STATE, debounce counters=0,
//   every channel in ARMED; reset mid-debounce or mid-handshake aborts it immediately.
//  Per-channel FSM ARMED/BLANK. pin_s = sampled pin; prev = pin_s from previous cycle.
//  ARMED, enabled: event = rise(~prev&pin_s) | fall(prev&~pin_s) | change(prev^pin_s)
//   | level(~pin_s, asserted every cycle while low). Event sets pending[i] next clock.
//  Edge event with debounce_en[i]=1 -> BLANK, counter loads DEBOUNCE_TIMEOUT; edges ignored.
//  BLANK: counter decrements each cycle; at 1 -> ARMED; prev keeps tracking pin_s, so no
//   retroactive edge fires on exit. Level mode never enters BLANK (debounce_en ignored).
//  int_enable[i]=0: no events, BLANK aborted to ARMED, prev still tracks pin; pending kept.
//  sense_control change takes effect next cycle; an active BLANK runs to completion.
//  Pending: set and pending_clr same cycle -> stays set (event never lost).
//  Latency: pin transition at cycle t -> pending high at t+1 -> irq_valid high at t+2.
//  Arbiter (registered): when irq_valid=0 and |pending, load irq_id = lowest set index,
//   irq_valid=1. irq_id stable while irq_valid=1; higher-priority arrivals wait.
//  irq_valid&irq_ack: clears pending[irq_id] (unless re-set same cycle), irq_valid=0 next
//   cycle; re-arbitration one cycle later (one idle cycle between grants).
//  pending_clr of pending[irq_id] while irq_valid=1 without ack: request withdrawn,
//   irq_valid=0 next cycle. irq_ack while irq_valid=0 is ignored.
//  Level mode held low: pending re-sets right after ack, next grant after idle cycle.
// CONFIGURATION
//  EXT_INT_SYNC_EN defined: pin_s from 2-flop synchronizer per pin (reset to PIN_IDLE_STATE);
//   all pin-to-pending latencies +2 cycles (pending t+3, irq_valid t+4).
//  Undefined: pin_s = int_pin directly; pins must be synchronous to clk.
// TESTING
//  1 Reset release, pins idle high, all enabled fall -> pending=0, irq_valid=0 for 50 cycles.
//  2 ch2 fall, debounce off, pin 1->0 at t -> pending=4'b0100 at t+1, irq_valid,irq_id=2 at
//    t+2; ack at t+5 -> pending=0, irq_valid=0 at t+6.
//  3 ch0 rise, debounce on, pin toggles every 3 cycles for 18 cycles after first rise ->
//    exactly one pending set; a clean rise at +25 sets pending again.
//  4 ch3 and ch1 fall same cycle -> grant irq_id=1; ack -> idle cycle -> grant irq_id=3.
//  5 ch1 change mode, pending set; pending_clr[1] same cycle as new edge -> pending[1]=1;
//    pending_clr[1] during valid without ack -> irq_valid drops next cycle.
//  6 ch0 low-level, pin held low, ack each grant -> re-grant every 3 cycles; int_enable[0]=0
//    -> no new grants, existing pending remains until cleared.

Source files
------------

// File: rtl/ext_int_controller_if.sv
// Request channel between the external interrupt controller and the interrupt unit.
// The controller presents one request (valid + channel id) and the unit accepts it with ack.
interface ext_int_controller_if #(
    parameter int ID_W = 2
);
    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;

    modport master (
        output irq_valid,
        output irq_id,
        input  irq_ack
    );

    modport slave (
        input  irq_valid,
        input  irq_id,
        output irq_ack
    );
endinterface

// File: rtl/ext_int_controller.sv
// Multi-channel external interrupt controller.
// Each pin has an enable, a sense mode (rise/fall/change/low-level) and an optional
// debounce blanking window. Detected events latch into write-1-to-clear pending flags,
// which a registered fixed-priority arbiter (channel 0 highest) presents as one
// valid/ack request on the irq_bus interface.
// Optional feature: define EXT_INT_SYNC_EN to pass every pin through a 2-flop
// synchronizer before detection (adds two cycles of pin-to-pending latency).
module ext_int_controller #(
    parameter int   NUM_CHANNELS     = 4,
    parameter logic PIN_IDLE_STATE   = 1'b1,
    parameter int   DEBOUNCE_TIMEOUT = 20,
    parameter int   DEBOUNCE_CNT_W   = $clog2(DEBOUNCE_TIMEOUT + 1),
    parameter int   ID_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CHANNELS-1:0]   int_pin,
    input  logic [NUM_CHANNELS-1:0]   int_enable,
    input  logic [2*NUM_CHANNELS-1:0] sense_control,
    input  logic [NUM_CHANNELS-1:0]   debounce_en,
    input  logic [NUM_CHANNELS-1:0]   pending_clr,
    output logic [NUM_CHANNELS-1:0]   pending,
    ext_int_controller_if.master      irq_bus
);

    typedef enum logic {
        ARMED = 1'b0,
        BLANK = 1'b1
    } ch_state_t;

    localparam logic [1:0] SENSE_RISE   = 2'b00;
    localparam logic [1:0] SENSE_FALL   = 2'b01;
    localparam logic [1:0] SENSE_CHANGE = 2'b10;

    logic [NUM_CHANNELS-1:0]   pin_s;
    logic [NUM_CHANNELS-1:0]   prev_q;
    ch_state_t                 state_q [NUM_CHANNELS];
    ch_state_t                 state_d [NUM_CHANNELS];
    logic [DEBOUNCE_CNT_W-1:0] cnt_q   [NUM_CHANNELS];
    logic [DEBOUNCE_CNT_W-1:0] cnt_d   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]   event_hit;

    logic [NUM_CHANNELS-1:0]   pending_q;
    logic [NUM_CHANNELS-1:0]   pending_d;
    logic [NUM_CHANNELS-1:0]   ack_mask;
    logic                      clr_hit;
    logic                      valid_q;
    logic                      valid_d;
    logic [ID_W-1:0]           id_q;
    logic [ID_W-1:0]           id_d;
    logic [ID_W-1:0]           lowest_id;

`ifdef EXT_INT_SYNC_EN
    logic [NUM_CHANNELS-1:0]   sync1_q;
    logic [NUM_CHANNELS-1:0]   sync2_q;

    // Two-flop synchronizer bringing asynchronous pins into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= {NUM_CHANNELS{PIN_IDLE_STATE}};
            sync2_q <= {NUM_CHANNELS{PIN_IDLE_STATE}};
        end else begin
            sync1_q <= int_pin;
            sync2_q <= sync1_q;
        end
    end

    assign pin_s = sync2_q;
`else
    assign pin_s = int_pin;
`endif

    // Per-channel state: pin history, ARMED/BLANK state and debounce counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= {NUM_CHANNELS{PIN_IDLE_STATE}};
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= ARMED;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q <= pin_s;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Event detection and ARMED/BLANK transitions; pin history keeps tracking while blanked.
    always_comb begin
        logic [1:0] mode;
        logic       rise;
        logic       fall;
        logic       edge_hit;
        logic       level_hit;

        mode      = 2'b00;
        rise      = 1'b0;
        fall      = 1'b0;
        edge_hit  = 1'b0;
        level_hit = 1'b0;
        event_hit = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            mode      = sense_control[2*i +: 2];
            rise      = ~prev_q[i] & pin_s[i];
            fall      = prev_q[i] & ~pin_s[i];
            edge_hit  = 1'b0;
            level_hit = 1'b0;
            case (mode)
                SENSE_RISE:   edge_hit  = rise;
                SENSE_FALL:   edge_hit  = fall;
                SENSE_CHANGE: edge_hit  = rise | fall;
                default:      level_hit = ~pin_s[i];
            endcase

            if (!int_enable[i]) begin
                state_d[i] = ARMED;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ARMED: begin
                        event_hit[i] = edge_hit | level_hit;
                        if (edge_hit && debounce_en[i]) begin
                            state_d[i] = BLANK;
                            cnt_d[i]   = DEBOUNCE_CNT_W'(DEBOUNCE_TIMEOUT);
                        end
                    end
                    BLANK: begin
                        if (cnt_q[i] <= DEBOUNCE_CNT_W'(1)) begin
                            state_d[i] = ARMED;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DEBOUNCE_CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ARMED;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Pending update and request arbitration; a new event always wins over a clear.
    always_comb begin
        ack_mask  = '0;
        clr_hit   = 1'b0;
        lowest_id = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (id_q == ID_W'(i)) begin
                ack_mask[i] = valid_q & irq_bus.irq_ack;
                clr_hit     = clr_hit | pending_clr[i];
            end
        end
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_id = ID_W'(i);
            end
        end

        pending_d = (pending_q & ~pending_clr & ~ack_mask) | event_hit;

        valid_d = valid_q;
        id_d    = id_q;
        if (valid_q) begin
            if (irq_bus.irq_ack || clr_hit) begin
                valid_d = 1'b0;
            end
        end else if (|pending_q) begin
            valid_d = 1'b1;
            id_d    = lowest_id;
        end
    end

    // Pending flags and the registered request toward the interrupt unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
        end
    end

    assign pending           = pending_q;
    assign irq_bus.irq_valid = valid_q;
    assign irq_bus.irq_id    = id_q;

endmodule

// File: tb/tb_ext_int_controller.sv
// Self-checking bench for ext_int_controller: directed scenarios plus a randomized run,
// all checked against a cycle-stepped reference model that tracks blanking windows as
// cycle timestamps and arbitrates by isolating the lowest pending bit.
module tb_ext_int_controller;

    localparam int N       = 4;
    localparam int TIMEOUT = 20;
    localparam int ID_W    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   int_pin;
    logic [N-1:0]   int_enable;
    logic [2*N-1:0] sense_control;
    logic [N-1:0]   debounce_en;
    logic [N-1:0]   pending_clr;
    logic [N-1:0]   pending;

    ext_int_controller_if #(.ID_W(ID_W)) bus ();

    ext_int_controller #(
        .NUM_CHANNELS    (N),
        .PIN_IDLE_STATE  (1'b1),
        .DEBOUNCE_TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .int_pin      (int_pin),
        .int_enable   (int_enable),
        .sense_control(sense_control),
        .debounce_en  (debounce_en),
        .pending_clr  (pending_clr),
        .pending      (pending),
        .irq_bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0]    m_prev;
    logic [N-1:0]    m_pending;
    logic            m_valid;
    logic [ID_W-1:0] m_id;
    int              m_blank_until [N];
    int              cyc;

    int total;
    int bad;

    // Advance one clock: compute the model's next state from the inputs the DUT is
    // about to sample, take the edge, commit, then settle 1 time unit past the edge.
    task automatic tick();
        logic [N-1:0]    n_prev, n_pending, ev, ack_mask, low_bit;
        logic            n_valid;
        logic [ID_W-1:0] n_id;
        int              n_blank [N];
        logic [1:0]      mode;
        logic            rose, fell, edge_seen;

        n_blank = m_blank_until;
        if (rst) begin
            n_prev    = '1;
            n_pending = '0;
            n_valid   = 1'b0;
            n_id      = '0;
            for (int i = 0; i < N; i++) n_blank[i] = cyc;
        end else begin
            ev = '0;
            for (int i = 0; i < N; i++) begin
                mode      = sense_control[2*i +: 2];
                rose      = !m_prev[i] && int_pin[i];
                fell      = m_prev[i] && !int_pin[i];
                edge_seen = (mode == 2'd0) ? rose :
                            (mode == 2'd1) ? fell :
                            (mode == 2'd2) ? (rose || fell) : 1'b0;
                if (!int_enable[i]) begin
                    n_blank[i] = cyc;
                end else if (cyc > m_blank_until[i]) begin
                    if (mode == 2'd3 && !int_pin[i]) ev[i] = 1'b1;
                    if (edge_seen) begin
                        ev[i] = 1'b1;
                        if (debounce_en[i]) n_blank[i] = cyc + TIMEOUT;
                    end
                end
            end
            ack_mask  = (m_valid && bus.irq_ack) ? (N'(1) << m_id) : '0;
            n_pending = (m_pending & ~pending_clr & ~ack_mask) | ev;
            n_prev    = int_pin;
            n_valid   = m_valid;
            n_id      = m_id;
            if (m_valid) begin
                if (bus.irq_ack || pending_clr[m_id]) n_valid = 1'b0;
            end else if (m_pending != '0) begin
                low_bit = m_pending & (~m_pending + 1'b1);
                n_valid = 1'b1;
                n_id    = ID_W'($clog2(low_bit));
            end
        end
        @(posedge clk);
        m_prev        = n_prev;
        m_pending     = n_pending;
        m_valid       = n_valid;
        m_id          = n_id;
        m_blank_until = n_blank;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (pending !== '0 || bus.irq_valid !== 1'b0 || bus.irq_id !== '0) begin
            bad++;
            $display("[TB] FAIL reset_values: got p=%b v=%b id=%0d want p=0000 v=0 id=0",
                     pending, bus.irq_valid, bus.irq_id);
        end
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            total++;
            if (pending !== 4'b0000 || bus.irq_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_idle: cycle %0d got p=%b v=%b want p=0000 v=0",
                         k, pending, bus.irq_valid);
            end
        end
    endtask

    task automatic test_fall_basic();
        int_enable    = 4'b0100;
        sense_control = 8'b01010101;
        debounce_en   = 4'b0000;
        repeat (2) tick();
        int_pin[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bus.irq_ack = (k == 6);
            tick();
            bus.irq_ack = 1'b0;
            total++;
            if (pending !== m_pending || {bus.irq_valid, bus.irq_id} !== {m_valid, m_id}) begin
                bad++;
                $display("[TB] FAIL fall_model: t+%0d got p=%b v=%b id=%0d want p=%b v=%b id=%0d",
                         k, pending, bus.irq_valid, bus.irq_id, m_pending, m_valid, m_id);
            end
            if (k == 1) begin
                total++;
                if (pending !== 4'b0100 || bus.irq_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL fall_t1: got p=%b v=%b want p=0100 v=0", pending, bus.irq_valid);
                end
            end
            if (k == 2) begin
                total++;
                if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd2) begin
                    bad++;
                    $display("[TB] FAIL fall_t2: got v=%b id=%0d want v=1 id=2", bus.irq_valid, bus.irq_id);
                end
            end
            if (k == 6) begin
                total++;
                if (pending !== 4'b0000 || bus.irq_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL fall_t6: got p=%b v=%b want p=0000 v=0", pending, bus.irq_valid);
                end
            end
        end
        int_pin[2] = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_debounce();
        int   rises;
        logic last_p;

        int_enable    = 4'b0001;
        sense_control = 8'b01010100;
        debounce_en   = 4'b0001;
        int_pin[0]    = 1'b0;
        repeat (2) tick();
        rises  = 0;
        last_p = pending[0];
        for (int k = 0; k < 40; k++) begin
            if (k < 18) int_pin[0] = ((k / 3) % 2 == 0);
            else        int_pin[0] = (k >= 25);
            bus.irq_ack = bus.irq_valid;
            tick();
            total++;
            if (pending !== m_pending || {bus.irq_valid, bus.irq_id} !== {m_valid, m_id}) begin
                bad++;
                $display("[TB] FAIL debounce_model: k=%0d got p=%b v=%b id=%0d want p=%b v=%b id=%0d",
                         k, pending, bus.irq_valid, bus.irq_id, m_pending, m_valid, m_id);
            end
            if (pending[0] && !last_p) rises++;
            last_p = pending[0];
        end
        bus.irq_ack = 1'b0;
        total++;
        if (rises !== 2) begin
            bad++;
            $display("[TB] FAIL debounce_sets: got %0d pending sets want 2", rises);
        end
    endtask

    task automatic test_priority();
        int_enable    = 4'b1010;
        sense_control = 8'b01010101;
        debounce_en   = 4'b0000;
        tick();
        int_pin[1] = 1'b0;
        int_pin[3] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.irq_ack = (k == 3 || k == 5);
            tick();
            bus.irq_ack = 1'b0;
            total++;
            if (pending !== m_pending || {bus.irq_valid, bus.irq_id} !== {m_valid, m_id}) begin
                bad++;
                $display("[TB] FAIL prio_model: step %0d got p=%b v=%b id=%0d want p=%b v=%b id=%0d",
                         k, pending, bus.irq_valid, bus.irq_id, m_pending, m_valid, m_id);
            end
            if (k == 2) begin
                total++;
                if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd1) begin
                    bad++;
                    $display("[TB] FAIL prio_first: got v=%b id=%0d want v=1 id=1", bus.irq_valid, bus.irq_id);
                end
            end
            if (k == 3) begin
                total++;
                if (bus.irq_valid !== 1'b0 || pending !== 4'b1000) begin
                    bad++;
                    $display("[TB] FAIL prio_idle: got v=%b p=%b want v=0 p=1000", bus.irq_valid, pending);
                end
            end
            if (k == 4) begin
                total++;
                if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3) begin
                    bad++;
                    $display("[TB] FAIL prio_second: got v=%b id=%0d want v=1 id=3", bus.irq_valid, bus.irq_id);
                end
            end
        end
        int_pin[1] = 1'b1;
        int_pin[3] = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_w1c();
        int_enable    = 4'b0010;
        sense_control = 8'b01011001;
        debounce_en   = 4'b0000;
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) int_pin[1] = 1'b0;
            if (k == 2) int_pin[1] = 1'b1;
            pending_clr = (k == 2 || k == 4) ? 4'b0010 : 4'b0000;
            tick();
            pending_clr = '0;
            total++;
            if (pending !== m_pending || {bus.irq_valid, bus.irq_id} !== {m_valid, m_id}) begin
                bad++;
                $display("[TB] FAIL w1c_model: step %0d got p=%b v=%b id=%0d want p=%b v=%b id=%0d",
                         k, pending, bus.irq_valid, bus.irq_id, m_pending, m_valid, m_id);
            end
            if (k == 2) begin
                total++;
                if (pending !== 4'b0010 || bus.irq_valid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL w1c_set_wins: got p=%b v=%b want p=0010 v=1", pending, bus.irq_valid);
                end
            end
            if (k == 4) begin
                total++;
                if (bus.irq_valid !== 1'b0 || pending !== 4'b0000) begin
                    bad++;
                    $display("[TB] FAIL w1c_withdraw: got v=%b p=%b want v=0 p=0000", bus.irq_valid, pending);
                end
            end
        end
    endtask

    task automatic test_level();
        int vcnt;
        int last_rise;
        logic last_v;

        int_enable    = 4'b0001;
        sense_control = 8'b01011011;
        debounce_en   = 4'b0001;
        int_pin[0]    = 1'b0;
        vcnt      = 0;
        last_rise = -1;
        last_v    = bus.irq_valid;
        for (int k = 0; k < 20; k++) begin
            bus.irq_ack = (vcnt == 2);
            tick();
            total++;
            if (pending !== m_pending || {bus.irq_valid, bus.irq_id} !== {m_valid, m_id}) begin
                bad++;
                $display("[TB] FAIL level_model: k=%0d got p=%b v=%b id=%0d want p=%b v=%b id=%0d",
                         k, pending, bus.irq_valid, bus.irq_id, m_pending, m_valid, m_id);
            end
            if (bus.irq_valid && !last_v) begin
                if (last_rise >= 0) begin
                    total++;
                    if (k - last_rise !== 3) begin
                        bad++;
                        $display("[TB] FAIL level_regrant: got spacing %0d want 3", k - last_rise);
                    end
                end
                last_rise = k;
            end
            last_v = bus.irq_valid;
            vcnt   = bus.irq_valid ? vcnt + 1 : 0;
        end
        bus.irq_ack = 1'b0;
        int_enable  = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (pending[0] !== 1'b1 || {bus.irq_valid, bus.irq_id} !== {m_valid, m_id}) begin
                bad++;
                $display("[TB] FAIL level_disabled: k=%0d got p=%b v=%b want p0=1 v=%b",
                         k, pending, bus.irq_valid, m_valid);
            end
        end
        pending_clr = 4'b0001;
        tick();
        pending_clr = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (pending !== 4'b0000 || bus.irq_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL level_cleared: k=%0d got p=%b v=%b want p=0000 v=0",
                         k, pending, bus.irq_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if (k % 50 == 0) begin
                int_enable    = N'($urandom);
                sense_control = (2*N)'($urandom);
                debounce_en   = N'($urandom);
            end
            rst         = ($urandom_range(0, 299) == 0);
            int_pin     = int_pin ^ (N'($urandom) & N'($urandom));
            pending_clr = N'($urandom) & N'($urandom) & N'($urandom);
            bus.irq_ack = ($urandom_range(0, 2) == 0);
            tick();
            total++;
            if (pending !== m_pending || {bus.irq_valid, bus.irq_id} !== {m_valid, m_id}) begin
                bad++;
                $display("[TB] FAIL random_model: k=%0d got p=%b v=%b id=%0d want p=%b v=%b id=%0d",
                         k, pending, bus.irq_valid, bus.irq_id, m_pending, m_valid, m_id);
            end
        end
        rst         = 1'b0;
        pending_clr = '0;
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        cyc           = 0;
        rst           = 1'b1;
        int_pin       = '1;
        int_enable    = '1;
        sense_control = 8'b01010101;
        debounce_en   = '0;
        pending_clr   = '0;
        bus.irq_ack   = 1'b0;
        m_prev        = '1;
        m_pending     = '0;
        m_valid       = 1'b0;
        m_id          = '0;
        for (int i = 0; i < N; i++) m_blank_until[i] = -1;

        test_reset();
        test_fall_basic();
        test_debounce();
        test_priority();
        test_w1c();
        test_level();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
